// File: rtl/receiver.sv
// UART receiver: 8N1, LSB first, 8x oversampling from an external baud strobe.
// rxd and bclk_8 are synchronized into sysclk; the FSM advances only on ticks
// (rising edges of the synchronized bclk_8).
// Optional error flags are built only when RX_ERR_EN is defined.
module receiver #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       bclk_8,
  input  logic       rdr_readH,
  output logic [7:0] RDR,
  output logic       rxd_readyH,
  output logic       frame_errH,
  output logic       overrun_errH
);

  // count value at the last tick of a bit period, and at mid start bit
  localparam logic [2:0] CNT_LAST = 3'(OVERSAMPLE - 1);
  localparam logic [2:0] CNT_MID  = 3'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // synchronizers
  logic rxd_m_q, rxd_s_q;
  logic bclk_m_q, bclk_s_q, bclk_d_q;
  logic rxd_s, tick;

  // FSM and datapath state
  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rdr_q, rdr_d;
  logic       ready_q, ready_d;
  logic       byte_done;

  // two-flop synchronizers; rxd idles high, bclk_8 idles low
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      rxd_m_q  <= 1'b1;
      rxd_s_q  <= 1'b1;
      bclk_m_q <= 1'b0;
      bclk_s_q <= 1'b0;
      bclk_d_q <= 1'b0;
    end else begin
      rxd_m_q  <= rxd;
      rxd_s_q  <= rxd_m_q;
      bclk_m_q <= bclk_8;
      bclk_s_q <= bclk_m_q;
      bclk_d_q <= bclk_s_q;
    end
  end

  assign rxd_s = rxd_s_q;
  assign tick  = bclk_s_q & ~bclk_d_q;

  // state register and datapath flops
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= 3'd0;
      bitcnt_q <= 4'd0;
      shreg_q  <= 8'h00;
      rdr_q    <= 8'h00;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      rdr_q    <= rdr_d;
      ready_q  <= ready_d;
    end
  end

  // next-state: everything holds except on ticks
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            count_d = 3'd0;
          end
        end
        START: begin
          if (count_q == CNT_MID) begin
            count_d = 3'd0;
            if (!rxd_s) begin
              state_d  = DATA;
              bitcnt_d = 4'd0;
            end else begin
              // glitch, not a real start bit
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + 3'd1;
          end
        end
        DATA: begin
          count_d = count_q + 3'd1;
          if (count_q == CNT_LAST) begin
            shreg_d  = {rxd_s, shreg_q[7:1]};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              state_d = STOP;
              count_d = 3'd0;
            end
          end
        end
        STOP: begin
          count_d = count_q + 3'd1;
          if (count_q == CNT_LAST) begin
            byte_done = 1'b1;
            state_d   = IDLE;
            count_d   = 3'd0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = 3'd0;
        end
      endcase
    end
  end

  // receive data register: a new byte always lands, and set beats a read
  always_comb begin
    rdr_d   = rdr_q;
    ready_d = ready_q;
    if (byte_done) begin
      rdr_d   = shreg_q;
      ready_d = 1'b1;
    end else if (rdr_readH) begin
      ready_d = 1'b0;
    end
  end

  assign RDR        = rdr_q;
  assign rxd_readyH = ready_q;

`ifdef RX_ERR_EN
  logic fe_q, fe_d, ov_q, ov_d;

  // error flags refresh on every completed byte
  always_comb begin
    fe_d = fe_q;
    ov_d = ov_q;
    if (byte_done) begin
      fe_d = ~rxd_s;
      ov_d = ready_q;
    end
  end

  // error flag registers
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  end

  assign frame_errH   = fe_q;
  assign overrun_errH = ov_q;
`else
  assign frame_errH   = 1'b0;
  assign overrun_errH = 1'b0;
`endif

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: acts as baud generator and transmitter, keeps a
// frame-level model (tick index since start detection) and checks every cycle.
module tb_receiver;

  logic       sysclk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       bclk_8 = 1'b0;
  logic       rdr_readH = 1'b0;
  logic [7:0] RDR;
  logic       rxd_readyH, frame_errH, overrun_errH;

  int n_vec = 0;
  int n_err = 0;

`ifdef RX_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  receiver #(.OVERSAMPLE(8)) dut (
    .sysclk(sysclk), .rst(rst), .rxd(rxd), .bclk_8(bclk_8),
    .rdr_readH(rdr_readH), .RDR(RDR), .rxd_readyH(rxd_readyH),
    .frame_errH(frame_errH), .overrun_errH(overrun_errH)
  );

  always #5 sysclk = ~sysclk;

  // 8x baud strobe: period 4 sysclk, so one bit = 32 sysclk
  logic [1:0] bcnt = 2'd0;
  always begin
    @(posedge sysclk);
    #1;
    bcnt   = bcnt + 2'd1;
    bclk_8 = bcnt[1];
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // model: delayed views of the inputs plus frame decode by tick index
  logic       mr1, mrs, mb1, mb2, mb3;
  bit         act;
  int         phase;
  logic [7:0] mdata, m_rdr;
  logic       m_rdy, m_fe, m_ov;

  task automatic model_reset();
    mr1 = 1'b1; mrs = 1'b1;
    mb1 = 1'b0; mb2 = 1'b0; mb3 = 1'b0;
    act = 1'b0; phase = 0; mdata = 8'h00;
    m_rdr = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  // predicts outputs after the next rising edge from inputs present now
  task automatic model_step();
    logic tk, ln, done;
    tk = mb2 & ~mb3;
    ln = mrs;
    done = 1'b0;
    if (tk) begin
      if (!act) begin
        if (!ln) begin
          act = 1'b1;
          phase = 0;
        end
      end else begin
        phase++;
        if (phase == 4 && ln) act = 1'b0;
        else if (phase >= 12 && phase <= 68 && (phase % 8) == 4)
          mdata[(phase - 12) / 8] = ln;
        else if (phase == 76) begin
          done = 1'b1;
          act = 1'b0;
        end
      end
    end
    if (done) begin
      if (ERR) begin
        m_fe = ~ln;
        m_ov = m_rdy;
      end
      m_rdr = mdata;
      m_rdy = 1'b1;
    end else if (rdr_readH) begin
      m_rdy = 1'b0;
    end
    mb3 = mb2; mb2 = mb1; mb1 = bclk_8;
    mrs = mr1; mr1 = rxd;
  endtask

  // per-cycle compare against the model
  always @(negedge sysclk) begin
    if (!rst) model_reset();
    chk("cycle", {5'b0, RDR, rxd_readyH, frame_errH, overrun_errH},
                 {5'b0, m_rdr, m_rdy, m_fe, m_ov});
    if (rst) model_step();
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    cyc(32);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(32);
    end
    rxd = stop;
    cyc(32);
    rxd = 1'b1;
  endtask

  task automatic pulse_read();
    rdr_readH = 1'b1;
    cyc(1);
    rdr_readH = 1'b0;
  endtask

  initial begin
    cyc(4);
    chk("rst_rdr", {8'h0, RDR}, 16'h0000);
    chk("rst_flags", {13'h0, rxd_readyH, frame_errH, overrun_errH}, 16'h0000);
    rst = 1'b1;
    cyc(8);

    // basic byte
    send(8'h55, 1'b1);
    cyc(4);
    chk("rx55_rdr", {8'h0, RDR}, 16'h0055);
    chk("rx55_rdy", {15'h0, rxd_readyH}, 16'h0001);
    chk("rx55_fe", {15'h0, frame_errH}, 16'h0000);
    pulse_read();
    chk("read_clr", {15'h0, rxd_readyH}, 16'h0000);

    // back to back with reads
    send(8'hAF, 1'b1);
    chk("rxAF_rdr", {8'h0, RDR}, 16'h00AF);
    fork
      send(8'h00, 1'b1);
      begin cyc(3); pulse_read(); end
    join
    chk("rx00_rdr", {8'h0, RDR}, 16'h0000);
    chk("rx00_rdy", {15'h0, rxd_readyH}, 16'h0001);
    chk("rx00_ov", {15'h0, overrun_errH}, 16'h0000);
    pulse_read();

    // overrun
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    chk("ovr_rdr", {8'h0, RDR}, 16'h00C3);
    chk("ovr_rdy", {15'h0, rxd_readyH}, 16'h0001);
    chk("ovr_flag", {15'h0, overrun_errH}, {15'h0, ERR});
    pulse_read();

    // false start then a good byte
    rxd = 1'b0;
    cyc(8);
    rxd = 1'b1;
    cyc(40);
    chk("false_rdy", {15'h0, rxd_readyH}, 16'h0000);
    send(8'h55, 1'b1);
    chk("after_false_rdr", {8'h0, RDR}, 16'h0055);
    chk("after_false_ov", {15'h0, overrun_errH}, 16'h0000);
    pulse_read();

    // framing error
    send(8'hA5, 1'b0);
    cyc(40);
    chk("fe_rdr", {8'h0, RDR}, 16'h00A5);
    chk("fe_rdy", {15'h0, rxd_readyH}, 16'h0001);
    chk("fe_flag", {15'h0, frame_errH}, {15'h0, ERR});
    pulse_read();
    send(8'h7E, 1'b1);
    chk("fe_cleared", {15'h0, frame_errH}, 16'h0000);
    chk("rx7E_rdr", {8'h0, RDR}, 16'h007E);
    pulse_read();

    // reset during bit 4 of 8'hFF
    rxd = 1'b0;
    cyc(32);
    rxd = 1'b1;
    cyc(32 * 4 + 16);
    rst = 1'b0;
    cyc(2);
    chk("mid_rst_rdr", {8'h0, RDR}, 16'h0000);
    chk("mid_rst_flags", {13'h0, rxd_readyH, frame_errH, overrun_errH}, 16'h0000);
    cyc(4);
    rst = 1'b1;
    cyc(16 + 32 * 3 + 32 + 20);
    chk("abort_rdy", {15'h0, rxd_readyH}, 16'h0000);
    chk("abort_rdr", {8'h0, RDR}, 16'h0000);
    send(8'h12, 1'b1);
    chk("rx12_rdr", {8'h0, RDR}, 16'h0012);
    chk("rx12_rdy", {15'h0, rxd_readyH}, 16'h0001);
    cyc(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
